// File: rtl/reg_scan_display.sv
// reg_scan_display: scanned seven-segment driver for a 32-digit panel
// (4 banks x 8 digits). It shows eight 16-bit registers as hex, two registers
// per bank. Banks are scanned round-robin, with a dwell of DIV cycles per bank
// and an optional blanking gap of BLANK cycles between banks.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   reg_0..reg_7   register values; sampled once per frame, in LOAD only
//   disp_1..disp_8 segment buses {a,b,c,d,e,f,g,dp}, a = bit 7, active-high
//   sl_out         one-hot bank select, bank 0 = 4'b1000, active-high
//
// Optional feature: define SCAN_LZB_EN for per-register leading-zero blanking.
// The low digit of each register is always shown.
module reg_scan_display #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] reg_0,
    input  logic [15:0] reg_1,
    input  logic [15:0] reg_2,
    input  logic [15:0] reg_3,
    input  logic [15:0] reg_4,
    input  logic [15:0] reg_5,
    input  logic [15:0] reg_6,
    input  logic [15:0] reg_7,
    output logic [7:0]  disp_1,
    output logic [7:0]  disp_2,
    output logic [7:0]  disp_3,
    output logic [7:0]  disp_4,
    output logic [7:0]  disp_5,
    output logic [7:0]  disp_6,
    output logic [7:0]  disp_7,
    output logic [7:0]  disp_8,
    output logic [3:0]  sl_out
);

    localparam int unsigned MAX_DB  = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CNT_MAX = (MAX_DB > 32'd2) ? MAX_DB : 32'd2;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK == 32'd0) ? 32'd0 : BLANK - 32'd1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [1:0]       bank_q,  bank_d;
    logic [7:0][15:0] snap_q,  snap_d;
    logic [3:0]       sl_q,    sl_d;
    logic [63:0]      disp_q,  disp_d;
    logic [7:0][15:0] regs_c;

    assign regs_c = {reg_7, reg_6, reg_5, reg_4, reg_3, reg_2, reg_1, reg_0};

    // Hex nibble to segment pattern {a..g,dp}; dp always off.
    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h1A;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Four digit patterns of one register, most significant nibble first.
    function automatic logic [31:0] reg_digits(input logic [15:0] v);
        logic [31:0] d;
        d = {seg7(v[15:12]), seg7(v[11:8]), seg7(v[7:4]), seg7(v[3:0])};
`ifdef SCAN_LZB_EN
        // Blank a run of leading zero nibbles; digit [3:0] is never blanked.
        if (v[15:4] == 12'h000) begin
            d[31:8] = 24'h000000;
        end else if (v[15:8] == 8'h00) begin
            d[31:16] = 16'h0000;
        end else if (v[15:12] == 4'h0) begin
            d[31:24] = 8'h00;
        end
`endif
        return d;
    endfunction

    // Next-state, dwell counter, snapshot and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bank_d  = bank_q;
        snap_d  = snap_q;
        sl_d    = 4'b0000;
        disp_d  = 64'h0;

        case (state_q)
            ST_LOAD: begin
                snap_d  = regs_c;
                state_d = ST_SHOW;
                bank_d  = 2'd0;
                cnt_d   = '0;
            end
            ST_SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (BLANK != 32'd0) begin
                        state_d = ST_GAP;
                    end else if (bank_q == 2'd3) begin
                        state_d = ST_LOAD;
                    end else begin
                        bank_d = 2'(bank_q + 2'd1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (bank_q == 2'd3) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SHOW;
                        bank_d  = 2'(bank_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the state being executed, so they lag it by one edge.
        if (state_q == ST_SHOW) begin
            sl_d   = 4'b1000 >> bank_q;
            disp_d = {reg_digits(snap_q[{bank_q, 1'b0}]),
                      reg_digits(snap_q[{bank_q, 1'b1}])};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            bank_q  <= 2'd0;
            snap_q  <= '0;
            sl_q    <= 4'b0000;
            disp_q  <= 64'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            snap_q  <= snap_d;
            sl_q    <= sl_d;
            disp_q  <= disp_d;
        end
    end

    assign sl_out = sl_q;
    assign disp_1 = disp_q[63:56];
    assign disp_2 = disp_q[55:48];
    assign disp_3 = disp_q[47:40];
    assign disp_4 = disp_q[39:32];
    assign disp_5 = disp_q[31:24];
    assign disp_6 = disp_q[23:16];
    assign disp_7 = disp_q[15:8];
    assign disp_8 = disp_q[7:0];

endmodule

// File: tb/tb_reg_scan_display.sv
// Testbench for reg_scan_display. Two instances share the register inputs:
// one with DIV=4/BLANK=2 (25-cycle frame) and one with DIV=4/BLANK=0
// (17-cycle frame). A frame-position reference model pushes the expected
// outputs per clock edge; a monitor pops and compares just after each edge.
module tb_reg_scan_display;

    localparam int unsigned DIV_T   = 4;
    localparam int unsigned BLANK_T = 2;
    localparam int unsigned F_MAIN  = 1 + 4 * (DIV_T + BLANK_T);
    localparam int unsigned F_NG    = 1 + 4 * DIV_T;

    typedef struct packed {
        logic [3:0]  sl;
        logic [63:0] disp;
        logic [3:0]  sl_ng;
        logic [63:0] disp_ng;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0][15:0] regs;

    logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [7:0] n1, n2, n3, n4, n5, n6, n7, n8;
    logic [3:0] sl_out, sl_ng;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t exp_q[$];
    int unsigned e_main = 0;
    int unsigned e_ng   = 0;
    logic [7:0][15:0] snap_main = '0;
    logic [7:0][15:0] snap_ng   = '0;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    always #5 clk = ~clk;

    reg_scan_display #(.DIV(DIV_T), .BLANK(BLANK_T)) dut (
        .clk(clk), .rst(rst),
        .reg_0(regs[0]), .reg_1(regs[1]), .reg_2(regs[2]), .reg_3(regs[3]),
        .reg_4(regs[4]), .reg_5(regs[5]), .reg_6(regs[6]), .reg_7(regs[7]),
        .disp_1(d1), .disp_2(d2), .disp_3(d3), .disp_4(d4),
        .disp_5(d5), .disp_6(d6), .disp_7(d7), .disp_8(d8),
        .sl_out(sl_out)
    );

    reg_scan_display #(.DIV(DIV_T), .BLANK(0)) dut_ng (
        .clk(clk), .rst(rst),
        .reg_0(regs[0]), .reg_1(regs[1]), .reg_2(regs[2]), .reg_3(regs[3]),
        .reg_4(regs[4]), .reg_5(regs[5]), .reg_6(regs[6]), .reg_7(regs[7]),
        .disp_1(n1), .disp_2(n2), .disp_3(n3), .disp_4(n4),
        .disp_5(n5), .disp_6(n6), .disp_7(n7), .disp_8(n8),
        .sl_out(sl_ng)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Hex text of a register as the panel should show it.
    function automatic logic [31:0] digits(input logic [15:0] v);
        logic [31:0] d;
        logic [7:0]  s;
        d = '0;
        for (int i = 3; i >= 0; i--) begin
            s = seg_tab[(v >> (4 * i)) & 16'hF];
`ifdef SCAN_LZB_EN
            if (i > 0 && 32'(v) < (32'd1 << (4 * i))) s = 8'h00;
`endif
            d[8 * i +: 8] = s;
        end
        return d;
    endfunction

    // Expected {sl_out, disp} for frame position p (0 = LOAD cycle).
    function automatic logic [67:0] model_out(input int unsigned p, input int unsigned blank,
                                              input logic [7:0][15:0] s);
        int unsigned q, bank, off;
        logic [67:0] r;
        r = '0;
        if (p != 0) begin
            q    = p - 1;
            bank = q / (DIV_T + blank);
            off  = q % (DIV_T + blank);
            if (off < DIV_T) begin
                r[67:64] = 4'(8 >> bank);
                r[63:32] = digits(s[2 * bank]);
                r[31:0]  = digits(s[2 * bank + 1]);
            end
        end
        return r;
    endfunction

    // Reference model: one expected entry per clock edge.
    always @(posedge clk) begin
        exp_t x;
        logic [67:0] m, g;
        int unsigned p, pn;
        if (rst) begin
            e_main = 0;
            e_ng   = 0;
            x      = '0;
        end else begin
            p  = e_main % F_MAIN;
            pn = e_ng % F_NG;
            if (p == 0)  snap_main = regs;
            if (pn == 0) snap_ng   = regs;
            m = model_out(p, BLANK_T, snap_main);
            g = model_out(pn, 0, snap_ng);
            x.sl      = m[67:64];
            x.disp    = m[63:0];
            x.sl_ng   = g[67:64];
            x.disp_ng = g[63:0];
            e_main++;
            e_ng++;
        end
        exp_q.push_back(x);
    end

    // Monitor: compare DUT outputs shortly after each edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd0, 64'd1);
        end else begin
            x = exp_q.pop_front();
            check("sl_out", 64'(sl_out), 64'(x.sl));
            check("disp", {d1, d2, d3, d4, d5, d6, d7, d8}, x.disp);
            check("sl_out_nogap", 64'(sl_ng), 64'(x.sl_ng));
            check("disp_nogap", {n1, n2, n3, n4, n5, n6, n7, n8}, x.disp_ng);
            check("onehot", 64'($onehot0(sl_out) && $onehot0(sl_ng)), 64'd1);
        end
    end

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'($urandom);
        return v >> (4 * $urandom_range(0, 4));
    endfunction

    task automatic rand_cycles(input int n, input bit keep6);
        for (int i = 0; i < n; i++) begin
            int unsigned k;
            @(negedge clk);
            k = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0 && !(keep6 && k == 6)) regs[k] = rand_val();
        end
    endtask

    // Wait for the edge that executes main-frame position pos (bounded).
    task automatic wait_main_pos(input int unsigned pos);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (e_main != 0 && (e_main - 1) % F_MAIN == pos) hit = 1'b1;
        end
        check("wait_frame_pos", 64'(hit), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = rand_val();
        regs[0] = 16'h1234;
        regs[1] = 16'hABCD;
        regs[6] = 16'h0000;

        // Reset held: outputs must be idle even before any edge.
        #2;
        check("rst_sl", 64'(sl_out), 64'd0);
        check("rst_disp", {d1, d2, d3, d4, d5, d6, d7, d8}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // During bank 1 of the first frame, reg_6 changes 0000 -> FFFF.
        wait_main_pos(8);
        @(negedge clk);
        regs[6] = 16'hFFFF;
        rand_cycles(60, 1'b1);

        // Async reset during bank 2.
        wait_main_pos(14);
        check("bank2_sl", 64'(sl_out), 64'h2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_sl", 64'(sl_out), 64'd0);
        check("async_rst_disp", {d1, d2, d3, d4, d5, d6, d7, d8}, 64'd0);
        check("async_rst_sl_ng", 64'(sl_ng), 64'd0);
        check("async_rst_disp_ng", {n1, n2, n3, n4, n5, n6, n7, n8}, 64'd0);
        regs[0] = 16'h00A5;
        regs[1] = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rand_cycles(30, 1'b1);
        rand_cycles(60, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
